// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the staged reset sequencer.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      HOLD = 2'd0,
      GAP  = 2'd1,
      RUN  = 2'd2
   } seq_state_t;

   localparam int DEF_NUM_STAGES      = 3;
   localparam int DEF_HOLD_CYCLES     = 16;
   localparam int DEF_STAGE_GAP       = 8;
   localparam int DEF_DEBOUNCE_CYCLES = 1024;

   // Counter width for a given terminal count; one spare bit so it never wraps.
   function automatic int cnt_width(input int terminal);
      return $clog2(terminal > 1 ? terminal : 1) + 1;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizes the raw active-low button and accepts a level change only
// after it has been stable for DEBOUNCE_CYCLES clocks.
module button_debounce
   import reset_seq_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic level,
   output logic press
);

   localparam int              DB_W    = cnt_width(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic            sync1;
   logic            sync2;
   logic [DB_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         level <= 1'b1;
         press <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= btn_n;
         sync2 <= sync1;
         press <= 1'b0;
         // Any return to the accepted level restarts the stability window.
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == DB_LAST) begin
            level <= sync2;
            press <= ~sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/reset_sequencer.sv
// Staged active-low reset release with hold and gap timing, restartable by
// a soft request or a debounced push-button.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_STAGES      = DEF_NUM_STAGES,
   parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
   parameter int STAGE_GAP       = DEF_STAGE_GAP,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  btn_n,
   input  logic                  soft_rst_req,
   output logic                  soft_rst_ack,
   output logic [NUM_STAGES-1:0] stage_rst_n,
   output logic                  seq_busy,
   output logic                  seq_done
);

   localparam int MAX_TERM = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES - 1 : STAGE_GAP - 1;
   localparam int CNT_W    = cnt_width(MAX_TERM);
   localparam int IDX_W    = cnt_width(NUM_STAGES);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STAGES - 1);

   seq_state_t            state;
   seq_state_t            state_nx;
   logic [CNT_W-1:0]      cnt;
   logic [CNT_W-1:0]      cnt_nx;
   logic [IDX_W-1:0]      idx;
   logic [IDX_W-1:0]      idx_nx;
   logic [NUM_STAGES-1:0] stages_nx;
   logic                  done_nx;
   logic                  ack_nx;
   logic                  btn_level;
   logic                  btn_press;
   logic                  trigger;

   button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .btn_n (btn_n),
      .level (btn_level),
      .press (btn_press)
   );

   // A held button keeps re-triggering, which pins the HOLD count at zero.
   assign trigger = soft_rst_req | btn_press | ~btn_level;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= HOLD;
         cnt          <= '0;
         idx          <= '0;
         stage_rst_n  <= '0;
         seq_busy     <= 1'b1;
         seq_done     <= 1'b0;
         soft_rst_ack <= 1'b0;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         idx          <= idx_nx;
         stage_rst_n  <= stages_nx;
         seq_busy     <= ~done_nx;
         seq_done     <= done_nx;
         soft_rst_ack <= ack_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      idx_nx   = idx;
      if (trigger) begin
         state_nx = HOLD;
         cnt_nx   = '0;
         idx_nx   = '0;
      end else begin
         case (state)
            HOLD: begin
               if (cnt == HOLD_LAST) begin
                  cnt_nx   = '0;
                  idx_nx   = IDX_W'(1);
                  state_nx = (NUM_STAGES == 1) ? RUN : GAP;
               end else begin
                  cnt_nx = cnt + 1'b1;
               end
            end
            GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt_nx = '0;
                  if (idx == LAST_IDX) state_nx = RUN;
                  else                 idx_nx   = idx + 1'b1;
               end else begin
                  cnt_nx = cnt + 1'b1;
               end
            end
            RUN:     ;
            default: state_nx = HOLD;
         endcase
      end
   end

   always_comb begin
      stages_nx = stage_rst_n;
      done_nx   = seq_done;
      ack_nx    = soft_rst_req;
      if (trigger) begin
         stages_nx = '0;
         done_nx   = 1'b0;
      end else begin
         case (state)
            HOLD: begin
               if (cnt == HOLD_LAST) begin
                  stages_nx[0] = 1'b1;
                  if (NUM_STAGES == 1) done_nx = 1'b1;
               end
            end
            GAP: begin
               if (cnt == GAP_LAST) begin
                  stages_nx = stages_nx | (NUM_STAGES'(1) << idx);
                  if (idx == LAST_IDX) done_nx = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Generates staged, active-low reset releases for the controller's downstream domains after power-up, a debounced push-button press, or a synchronous soft-reset request. It sits between the board-level reset source and the per-domain synchronizers, so each subsystem leaves reset in a fixed order with guaranteed hold and gap times. It also reports sequence progress to the control logic.

## Interface
Parameters:
- NUM_STAGES, 3, number of staged reset outputs (1..8)
- HOLD_CYCLES, 16, cycles all stages stay asserted before stage 0 releases (>=2)
- STAGE_GAP, 8, cycles between successive stage releases (>=1)
- DEBOUNCE_CYCLES, 1024, stable cycles needed to accept a button level change (>=2)

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- btn_n  input  1  raw push-button, active-low, asynchronous to clk
- soft_rst_req  input  1  single-cycle synchronous soft-reset request
- soft_rst_ack  output  1  one-cycle pulse: request accepted
- stage_rst_n  output  NUM_STAGES  per-domain active-low resets; bit 0 releases first
- seq_busy  output  1  high while any stage is still asserted
- seq_done  output  1  high once every stage has released

## Operation
- States: HOLD, GAP, RUN.
- rst asserted (asynchronously):
  - state = HOLD, counter = 0, stage index = 0
  - stage_rst_n = all 0, seq_busy = 1, seq_done = 0, soft_rst_ack = 0
  - button sync flops = 1, debounced level = 1 (released)
- HOLD: counter increments each cycle. On reaching HOLD_CYCLES-1:
  - release stage_rst_n[0]
  - counter clears
  - go to GAP, or to RUN if NUM_STAGES = 1
- GAP: counter increments. On reaching STAGE_GAP-1:
  - release the next stage
  - counter clears
  - go to RUN after the last stage is released, otherwise stay in GAP
- RUN: seq_done = 1, seq_busy = 0, all stage_rst_n = 1.
- Trigger: soft_rst_req high, or a debounced button level of 0 (pressed). A trigger in any state:
  - drives all stage_rst_n to 0 on the next edge
  - clears counter and stage index
  - enters HOLD, seq_done = 0, seq_busy = 1
- While the debounced button stays pressed, the HOLD counter is held at 0; the sequence starts only after release.
- soft_rst_ack pulses on the edge that registers an accepted soft_rst_req, in every state including mid-sequence. A request in the same cycle as a button trigger is still acked.
- Debounce:
  - btn_n passes through a 2-flop synchronizer.
  - A counter runs while the synchronized level differs from the debounced level and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
- Counter widths: $clog2 of the largest terminal count, plus 1; counters never wrap.

## Timing
- Release points, counting from the first rising edge after rst deasserts (edge 1):
  - stage_rst_n[0] rises on edge HOLD_CYCLES
  - stage k rises on edge HOLD_CYCLES + k*STAGE_GAP
- seq_done rises and seq_busy falls on the same edge as the last stage release.
- Soft trigger latency: request sampled on edge n → stage_rst_n all 0, seq_done 0, and soft_rst_ack 1 after edge n. The HOLD count restarts from edge n+1.
- Button latency: 2 sync cycles + DEBOUNCE_CYCLES, then 1 cycle to assert the stages.
- Glitch filtering: a bounce shorter than DEBOUNCE_CYCLES on btn_n has no effect.
- Outputs are registered and glitch-free. Only rst acts asynchronously.

## Structure
- Package reset_seq_pkg: the state enum type (HOLD, GAP, RUN) and the default parameter constants.
- Sub-module button_debounce: synchronizer, counter, and debounced level. It exposes a level output and a press pulse, and uses the same clk/rst.
- The top level holds the FSM, the shared counter, the stage index, and the output registers.

## Test plan
Use NUM_STAGES=3, HOLD_CYCLES=16, STAGE_GAP=8, DEBOUNCE_CYCLES=4.
- Power-up: release rst, no other stimulus → stage_rst_n goes 000→001 at edge 16, 011 at edge 24, 111 at edge 32; seq_done rises at edge 32.
- Soft reset in RUN: one-cycle soft_rst_req → soft_rst_ack=1 and stage_rst_n=000 the next cycle; same 16/8/8 release spacing follows.
- Soft reset mid-sequence: request at edge 20 (stage 0 released) → stages back to 000, ack pulses, seq_done stays 0, new release at edge 36.
- Button bounce: btn_n low for 3 cycles, then high → no output change. Held low for 20 cycles → stages go 000 about 7 cycles after the press and stay 000 until release; then 16/8/8 release spacing.
- Async reset mid-GAP: rst pulsed asynchronously between edges → stage_rst_n=000, seq_busy=1, seq_done=0 immediately, without waiting for a clock edge.
- Simultaneous soft_rst_req and debounced press → single restart, ack pulses once, sequence waits for button release.
